// File: rtl/stopwatch_ctrl.sv
// Stopwatch/timer control: sequences a 4-digit BCD MM:SS counter through
// idle/run/pause/lap/done from one-cycle button pulses and a seconds strobe.
module stopwatch_ctrl #(
  parameter logic [15:0] PRESET_BCD = 16'h0130
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_pulse,
  input  logic        lap_pulse,
  input  logic        clr_pulse,
  input  logic        mode_pulse,
  input  logic        sec_tick,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        count_down,
  output logic        done
);

  typedef enum logic [2:0] {StIdle, StRun, StPause, StLap, StDone} state_e;

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] lap_q;
  logic        count_down_q;

  logic        count_en;
  logic        hit_zero;
  logic [15:0] count_step;
  logic [15:0] reload;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so == 4'd9) begin
      so = 4'd0;
      if (st == 4'd5) begin
        st = 4'd0;
        if (mo == 4'd9) begin
          mo = 4'd0;
          mt = (mt == 4'd5) ? 4'd0 : mt + 4'd1;
        end else begin
          mo = mo + 4'd1;
        end
      end else begin
        st = st + 4'd1;
      end
    end else begin
      so = so + 4'd1;
    end
    return {mt, mo, st, so};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so == 4'd0) begin
      so = 4'd9;
      if (st == 4'd0) begin
        st = 4'd5;
        if (mo == 4'd0) begin
          mo = 4'd9;
          mt = (mt == 4'd0) ? 4'd5 : mt - 4'd1;
        end else begin
          mo = mo - 4'd1;
        end
      end else begin
        st = st - 4'd1;
      end
    end else begin
      so = so - 4'd1;
    end
    return {mt, mo, st, so};
  endfunction

  // Ticks count in RUN/LAP unless a clear wins the same cycle.
  always_comb begin
    count_en   = sec_tick && !clr_pulse && (state_q == StRun || state_q == StLap);
    count_step = count_down_q ? bcd_dec(count_q) : bcd_inc(count_q);
    hit_zero   = count_en && count_down_q && (count_step == 16'h0000);
    reload     = count_down_q ? PRESET_BCD : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      count_q      <= 16'h0000;
      lap_q        <= 16'h0000;
      count_down_q <= 1'b0;
    end else begin
      if (count_en) count_q <= count_step;
      case (state_q)
        StIdle: begin
          if (clr_pulse) begin
            count_q <= reload;
          end else if (start_pulse) begin
            state_q <= (count_down_q && count_q == 16'h0000) ? StDone : StRun;
          end else if (mode_pulse) begin
            count_down_q <= !count_down_q;
            count_q      <= count_down_q ? 16'h0000 : PRESET_BCD;
          end
        end
        StRun: begin
          if (clr_pulse) begin
            state_q <= StIdle;
            count_q <= reload;
          end else if (start_pulse) begin
            state_q <= StPause;
          end else if (lap_pulse) begin
            state_q <= StLap;
            lap_q   <= count_q;
          end
        end
        StLap: begin
          if (clr_pulse) begin
            state_q <= StIdle;
            count_q <= reload;
          end else if (start_pulse) begin
            state_q <= StPause;
          end else if (lap_pulse) begin
            state_q <= StRun;
          end
        end
        StPause: begin
          if (clr_pulse) begin
            state_q <= StIdle;
            count_q <= reload;
          end else if (start_pulse) begin
            state_q <= StRun;
          end
        end
        StDone: begin
          if (clr_pulse) begin
            state_q <= StIdle;
            count_q <= reload;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Reaching 00:00 while counting down overrides any coincident request.
      if (hit_zero) state_q <= StDone;
    end
  end

  assign running    = (state_q == StRun) || (state_q == StLap);
  assign lap_active = (state_q == StLap);
  assign done       = (state_q == StDone);
  assign count_down = count_down_q;
  assign disp_bcd   = lap_active ? lap_q : count_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random
// pulses checked against a seconds-based reference model.
module tb_stopwatch_ctrl;

  localparam logic [15:0] PRESET      = 16'h0130;
  localparam int          PRESET_SECS = 90;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3, M_DONE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_pulse = 1'b0, lap_pulse = 1'b0, clr_pulse = 1'b0;
  logic        mode_pulse = 1'b0, sec_tick = 1'b0;
  logic [15:0] disp_bcd;
  logic        running, lap_active, count_down, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time held as plain seconds, converted to BCD on output.
  int m_state, m_secs, m_lap, m_cd;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.PRESET_BCD(PRESET)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_pulse(start_pulse),
    .lap_pulse  (lap_pulse),
    .clr_pulse  (clr_pulse),
    .mode_pulse (mode_pulse),
    .sec_tick   (sec_tick),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .lap_active (lap_active),
    .count_down (count_down),
    .done       (done)
  );

  function automatic logic [15:0] to_bcd(input int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [19:0] model_out();
    logic [15:0] d;
    d = to_bcd(m_state == M_LAP ? m_lap : m_secs);
    return {d, (m_state == M_RUN || m_state == M_LAP), (m_state == M_LAP), m_cd[0],
            (m_state == M_DONE)};
  endfunction

  function automatic logic [19:0] dut_out();
    return {disp_bcd, running, lap_active, count_down, done};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_secs = 0; m_lap = 0; m_cd = 0;
  endtask

  task automatic model_step(input bit s, input bit l, input bit c, input bit m, input bit t);
    bit cnt;
    int pre, rl;
    pre = m_secs;
    rl  = m_cd ? PRESET_SECS : 0;
    cnt = t && !c && (m_state == M_RUN || m_state == M_LAP);
    if (cnt) m_secs = m_cd ? m_secs - 1 : (m_secs + 1) % 3600;
    if (c && m_state != M_IDLE) begin
      m_state = M_IDLE; m_secs = rl;
    end else if (c) begin
      m_secs = rl;
    end else begin
      case (m_state)
        M_IDLE:
          if (s) m_state = (m_cd != 0 && pre == 0) ? M_DONE : M_RUN;
          else if (m) begin m_cd = 1 - m_cd; m_secs = m_cd ? PRESET_SECS : 0; end
        M_RUN:
          if (s) m_state = M_PAUSE;
          else if (l) begin m_state = M_LAP; m_lap = pre; end
        M_LAP:
          if (s) m_state = M_PAUSE;
          else if (l) m_state = M_RUN;
        M_PAUSE:
          if (s) m_state = M_RUN;
        default: ;
      endcase
    end
    if (cnt && m_cd != 0 && m_secs == 0) m_state = M_DONE;
  endtask

  task automatic step(input bit s, input bit l, input bit c, input bit m, input bit t);
    start_pulse = s; lap_pulse = l; clr_pulse = c; mode_pulse = m; sec_tick = t;
    model_step(s, l, c, m, t);
    @(posedge clk);
    #1;
    start_pulse = 0; lap_pulse = 0; clr_pulse = 0; mode_pulse = 0; sec_tick = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (dut_out() !== 20'h0) begin
      n_fail++; $display("FAIL reset_values: got %h required %h", dut_out(), 20'h0);
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if (dut_out() !== model_out()) begin
      n_fail++; $display("FAIL post_reset: got %h required %h", dut_out(), model_out());
    end
  endtask

  task automatic test_up_count();
    do_reset();
    step(1, 0, 0, 0, 0);
    ticks(75);
    n_checks++;
    if (disp_bcd !== 16'h0115 || running !== 1'b1) begin
      n_fail++; $display("FAIL up_count_75: got %h/%b required 0115/1", disp_bcd, running);
    end
    step(1, 0, 0, 0, 0);
    ticks(3);
    n_checks++;
    if (disp_bcd !== 16'h0115 || running !== 1'b0 || dut_out() !== model_out()) begin
      n_fail++; $display("FAIL pause_hold: got %h required %h", dut_out(), model_out());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1, 0, 0, 0, 0);
    ticks(3599);
    n_checks++;
    if (disp_bcd !== 16'h5959) begin
      n_fail++; $display("FAIL wrap_5959: got %h required 5959", disp_bcd);
    end
    ticks(1);
    n_checks++;
    if (disp_bcd !== 16'h0000 || running !== 1'b1) begin
      n_fail++; $display("FAIL wrap_0000: got %h/%b required 0000/1", disp_bcd, running);
    end
    step(1, 0, 0, 0, 1);
    n_checks++;
    if (disp_bcd !== 16'h0001 || running !== 1'b0 || dut_out() !== model_out()) begin
      n_fail++; $display("FAIL tick_with_start: got %h required %h", dut_out(), model_out());
    end
  endtask

  task automatic test_lap();
    do_reset();
    step(1, 0, 0, 0, 0);
    ticks(10);
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (lap_active !== 1'b1 || disp_bcd !== 16'h0010) begin
      n_fail++; $display("FAIL lap_enter: got %h/%b required 0010/1", disp_bcd, lap_active);
    end
    ticks(5);
    n_checks++;
    if (disp_bcd !== 16'h0010 || m_secs != 15) begin
      n_fail++; $display("FAIL lap_frozen: got %h required 0010", disp_bcd);
    end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (disp_bcd !== 16'h0015 || lap_active !== 1'b0 || running !== 1'b1) begin
      n_fail++; $display("FAIL lap_exit: got %h/%b required 0015/0", disp_bcd, lap_active);
    end
    step(0, 1, 0, 0, 1);
    ticks(4);
    step(1, 0, 0, 0, 0);
    n_checks++;
    if (disp_bcd !== 16'h0020 || running !== 1'b0 || lap_active !== 1'b0) begin
      n_fail++; $display("FAIL lap_to_pause: got %h required %h", dut_out(), model_out());
    end
  endtask

  task automatic test_count_down();
    do_reset();
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (count_down !== 1'b1 || disp_bcd !== 16'h0130) begin
      n_fail++; $display("FAIL mode_toggle: got %h/%b required 0130/1", disp_bcd, count_down);
    end
    step(1, 0, 0, 0, 0);
    ticks(89);
    n_checks++;
    if (disp_bcd !== 16'h0001 || running !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL down_0001: got %h required %h", dut_out(), model_out());
    end
    ticks(1);
    n_checks++;
    if (disp_bcd !== 16'h0000 || done !== 1'b1 || running !== 1'b0) begin
      n_fail++; $display("FAIL down_done: got %h/%b/%b required 0000/1/0", disp_bcd, done,
                         running);
    end
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    n_checks++;
    if (disp_bcd !== 16'h0000 || done !== 1'b1 || lap_active !== 1'b0) begin
      n_fail++; $display("FAIL done_ignores: got %h required %h", dut_out(), model_out());
    end
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (disp_bcd !== 16'h0130 || done !== 1'b0 || count_down !== 1'b1 || running !== 1'b0) begin
      n_fail++; $display("FAIL done_clear: got %h required %h", dut_out(), model_out());
    end
  endtask

  task automatic test_priority();
    do_reset();
    step(1, 0, 0, 0, 0);
    ticks(5);
    step(1, 0, 1, 0, 1);
    n_checks++;
    if (disp_bcd !== 16'h0000 || running !== 1'b0) begin
      n_fail++; $display("FAIL clr_priority: got %h/%b required 0000/0", disp_bcd, running);
    end
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (count_down !== 1'b0 || running !== 1'b1) begin
      n_fail++; $display("FAIL mode_in_run: got %b required 0", count_down);
    end
    step(1, 1, 0, 1, 0);
    n_checks++;
    if (running !== 1'b0 || lap_active !== 1'b0 || count_down !== 1'b0) begin
      n_fail++; $display("FAIL start_over_lap: got %h required %h", dut_out(), model_out());
    end
    step(0, 1, 0, 1, 1);
    n_checks++;
    if (dut_out() !== model_out() || count_down !== 1'b0) begin
      n_fail++; $display("FAIL pause_ignores: got %h required %h", dut_out(), model_out());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 0, 0, 0, 0);
    ticks(7);
    step(0, 1, 0, 0, 0);
    ticks(2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_out() !== 20'h0) begin
      n_fail++; $display("FAIL async_reset: got %h required %h", dut_out(), 20'h0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    ticks(3);
    n_checks++;
    if (dut_out() !== 20'h0) begin
      n_fail++; $display("FAIL no_count_after_reset: got %h required %h", dut_out(), 20'h0);
    end
  endtask

  task automatic test_random();
    bit s, l, c, m, t;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      s = ($urandom % 25) == 0;
      l = ($urandom % 15) == 0;
      c = ($urandom % 250) == 0;
      m = ($urandom % 6) == 0;
      t = ($urandom % 2) == 0;
      step(s, l, c, m, t);
      n_checks++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %h required %h", i, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_wrap();
    test_lap();
    test_count_down();
    test_priority();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and count block for the lab stopwatch/timer. It consumes the one-cycle button pulses from the debounce/one-pulse front end (start/stop, lap, long-press clear, mode) and a one-cycle seconds strobe. It sequences a 4-digit BCD MM:SS counter through idle/run/pause/lap/done states. It drives the BCD value to the seven-segment scan logic plus status flags for LEDs.

## Interface
- PRESET_BCD, 16'h0130, count-down start value as BCD {min_tens, min_ones, sec_tens, sec_ones}; must be valid BCD ≤ 59:59
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start_pulse  input  1  one-cycle start/stop request (in1 button)
- lap_pulse  input  1  one-cycle lap request (in2 short press)
- clr_pulse  input  1  one-cycle clear request (in2 long press)
- mode_pulse  input  1  one-cycle up/down mode toggle
- sec_tick  input  1  one-cycle strobe, once per second, synchronous to clk
- disp_bcd  output  16  displayed value {min_tens, min_ones, sec_tens, sec_ones}
- running  output  1  high in RUN and LAP
- lap_active  output  1  high in LAP (display frozen)
- count_down  output  1  0 = count-up mode, 1 = count-down mode
- done  output  1  high in DONE

## Operation
- Registers: state, count[15:0] (live BCD), lap_reg[15:0], count_down.
- disp_bcd = lap_active ? lap_reg : count. All outputs decode from registers only; no input-to-output combinational path.
- Reload value is 16'h0000 when count_down = 0, and PRESET_BCD when count_down = 1.
- Request priority within a cycle: clr > start > lap > mode. At most one request acts per cycle; lower-priority pulses in the same cycle are dropped.
- IDLE:
  - start → RUN. If count_down = 1 and count = 0000, go to DONE instead.
  - mode → toggle count_down and load the new reload value.
  - clr → reload.
  - lap is ignored.
- RUN:
  - start → PAUSE.
  - lap → LAP; lap_reg <= current count.
  - clr → IDLE with reload.
- LAP:
  - Counting continues; display stays frozen.
  - lap → RUN (display live again).
  - start → PAUSE (display live).
  - clr → IDLE with reload.
- PAUSE:
  - start → RUN.
  - clr → IDLE with reload.
  - lap and mode are ignored.
- DONE:
  - clr → IDLE with reload.
  - All other requests are ignored. count holds 0000.
- mode_pulse is honoured only in IDLE.
- Counting happens when sec_tick = 1, state is RUN or LAP, and clr_pulse = 0. The state used is the one before the edge, so a tick coincident with start in RUN is still counted.
- Count-up: BCD increment. sec_ones 9→0 carries into sec_tens; sec_tens 5→0 carries into min_ones; min_ones 9→0 carries into min_tens. 59:59 → 00:00 wraps and counting continues.
- Count-down: BCD decrement with mirrored borrows (00 seconds → 59 and borrow a minute). A decrement that yields 00:00 moves state to DONE on the same edge.
- A long press always produces lap_pulse before clr_pulse. In RUN this enters LAP first, then clr forces IDLE. This is the intended behaviour.

## Timing
- Reset values: state = IDLE, count = 0000, lap_reg = 0000, count_down = 0. Outputs: disp_bcd = 0000, running = 0, lap_active = 0, done = 0.
- Reset is asynchronous and takes effect mid-count in any state. Counting resumes only after rst_n deasserts and a new start_pulse arrives.
- Request latency: state and flags change on the clk edge that samples the pulse, and are visible immediately after that edge (1 cycle).
- Tick latency: count, and disp_bcd when live, update on the edge that samples sec_tick.
- In LAP, disp_bcd does not change on ticks. On exit from LAP it shows the live count in the cycle after the exiting edge.
- No handshake. Every pulse is consumed in exactly one cycle and never queued.

## Test plan
- Up-count: reset, start, 75 ticks → disp_bcd = 16'h0115, running = 1. Start → PAUSE. 3 more ticks → still 0115.
- Wrap: up mode, count run to 59:59, one tick → 0000 with running still 1. Tick coincident with start in RUN → count increments and state = PAUSE.
- Lap: in RUN at 0010, lap → lap_active = 1. 5 ticks → disp_bcd = 0010 while count = 0015. Lap again → disp_bcd = 0015.
- Count-down: in IDLE, mode → count_down = 1, disp_bcd = 0130. Start, 90 ticks → disp_bcd = 0000, done = 1, running = 0. Start/lap ignored. Clr → IDLE at 0130.
- Priority: clr, start and sec_tick in the same cycle during RUN → IDLE, reload value shown, no count. Mode pulse in RUN or PAUSE → count_down unchanged.
- Async reset: assert rst_n low mid-cycle while in LAP with nonzero count → all outputs at reset values before the next clk edge.
